zoom_ram_arb: RTL and testbench

- Arbiter and sequencer that shares one single-port line RAM (2048x16, registered output, read-before-write) between two requesters in the ZOOM scaler.
- The line writer stores incoming pixels. The tap reader fetches pixels for interpolation.
- The block grants one access per cycle, registers the RAM address and control, and tracks read latency so read data returns with a valid strobe.
- It sits between the scaler line logic and the RAM instance.

---
 rtl/zoom_pkg.sv | 12 +
 rtl/zoom_rd_lat_pipe.sv | 30 +++
 rtl/zoom_ram_arb.sv | 91 +++++++++
 tb/tb_zoom_ram_arb.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/zoom_pkg.sv
// Shared types and default sizes for the ZOOM line-RAM arbiter.
package zoom_pkg;
    localparam int ZOOM_ADDR_W = 11;
    localparam int ZOOM_DATA_W = 16;
    localparam int RAM_RD_LAT  = 2;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_WR,
        GNT_RD
    } grant_t;
endpackage

// File: rtl/zoom_rd_lat_pipe.sv
// Read-return tracker: carries each read grant down a valid shift register
// and captures RAM read data one stage before the valid pops out, so data
// and strobe appear together.
module zoom_rd_lat_pipe #(
    parameter int DEPTH      = 3,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_gnt,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic                  rdout_valid,
    output logic [DATA_WIDTH-1:0] rdout_data
);
    logic [DEPTH-1:0] vld_pipe;

    // Shift the read grant along; reset drops anything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_pipe <= '0;
        else     vld_pipe <= {vld_pipe[DEPTH-2:0], rd_gnt};
    end

    // RAM data for a tracked read is live in the cycle before the last stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                   rdout_data <= '0;
        else if (vld_pipe[DEPTH-2]) rdout_data <= ram_rd_data;
    end

    assign rdout_valid = vld_pipe[DEPTH-1];
endmodule

// File: rtl/zoom_ram_arb.sv
// Shares one single-port line RAM between the line writer and the tap
// reader. Writes win conflicts until MAX_WR_BURST consecutive write grants
// have been given to a waiting reader, then the read gets one slot.
module zoom_ram_arb
    import zoom_pkg::*;
#(
    parameter int ADDR_WIDTH   = zoom_pkg::ZOOM_ADDR_W,
    parameter int DATA_WIDTH   = zoom_pkg::ZOOM_DATA_W,
    parameter int RAM_RD_LAT   = zoom_pkg::RAM_RD_LAT,
    parameter int MAX_WR_BURST = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rdout_valid,
    output logic [DATA_WIDTH-1:0] rdout_data,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic                  ram_wr_en,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic [15:0]           conflict_cnt
);
    localparam logic [3:0] MAXB = 4'(MAX_WR_BURST);

    grant_t     gnt;
    logic [3:0] burst_cnt;

    // One grant per cycle; nothing is granted while reset is held.
    always_comb begin
        gnt = GNT_NONE;
        if (!rst) begin
            if (wr_valid && (!rd_valid || burst_cnt < MAXB)) gnt = GNT_WR;
            else if (rd_valid)                               gnt = GNT_RD;
        end
    end

    assign wr_ready = (gnt == GNT_WR);
    assign rd_ready = (gnt == GNT_RD);

    // Count writes that jumped ahead of a waiting read; a read or an idle
    // reader restarts the window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                               burst_cnt <= '0;
        else if (!rd_valid || gnt == GNT_RD)   burst_cnt <= '0;
        else if (gnt == GNT_WR && burst_cnt < MAXB) burst_cnt <= burst_cnt + 4'd1;
    end

    // Register the RAM port from the granted request; address holds when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_addr    <= '0;
            ram_wr_data <= '0;
            ram_wr_en   <= 1'b0;
        end else begin
            ram_wr_en <= 1'b0;
            case (gnt)
                GNT_WR: begin
                    ram_addr    <= wr_addr;
                    ram_wr_data <= wr_data;
                    ram_wr_en   <= 1'b1;
                end
                GNT_RD:  ram_addr <= rd_addr;
                default: ;
            endcase
        end
    end

    // Saturating count of cycles where both requesters wanted the RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                          conflict_cnt <= '0;
        else if (wr_valid && rd_valid && conflict_cnt != 16'hFFFF) conflict_cnt <= conflict_cnt + 16'd1;
    end

    zoom_rd_lat_pipe #(
        .DEPTH      (1 + RAM_RD_LAT),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rd_lat_pipe (
        .clk         (clk),
        .rst         (rst),
        .rd_gnt      (gnt == GNT_RD),
        .ram_rd_data (ram_rd_data),
        .rdout_valid (rdout_valid),
        .rdout_data  (rdout_data)
    );
endmodule

// File: tb/tb_zoom_ram_arb.sv
// Scoreboard bench for zoom_ram_arb with a behavioural RAM and a reference
// model of arbitration, memory contents and conflict counting.
module tb_zoom_ram_arb;
    localparam int AW   = 11;
    localparam int DW   = 16;
    localparam int MAXB = 4;
    localparam int LAT  = 3;   // handshake cycle to rdout_valid cycle

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_valid = 1'b0, rd_valid = 1'b0;
    logic          wr_ready, rd_ready;
    logic [AW-1:0] wr_addr = '0, rd_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          rdout_valid;
    logic [DW-1:0] rdout_data;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wr_data;
    logic          ram_wr_en;
    logic [DW-1:0] ram_rd_data = '0;
    logic [15:0]   conflict_cnt;

    zoom_ram_arb #(.MAX_WR_BURST(MAXB)) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rdout_valid(rdout_valid), .rdout_data(rdout_data),
        .ram_addr(ram_addr), .ram_wr_data(ram_wr_data), .ram_wr_en(ram_wr_en),
        .ram_rd_data(ram_rd_data), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    // Single-port RAM, synchronous read, read-before-write.
    logic [DW-1:0] ram_mem [0:(1<<AW)-1];
    initial for (int i = 0; i < (1<<AW); i++) ram_mem[i] = '0;
    always @(posedge clk) begin
        if (ram_wr_en) ram_mem[ram_addr] <= ram_wr_data;
        ram_rd_data <= ram_mem[ram_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Reference model state
    typedef struct { logic [DW-1:0] d; int due; } exp_t;
    exp_t          sb_q[$];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    initial for (int i = 0; i < (1<<AW); i++) ref_mem[i] = '0;
    int            m_burst = 0;
    int            m_conf  = 0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_wdata = '0;
    logic          e_we = 1'b0;
    logic [DW-1:0] last_data = '0;

    // Monitor: pop the scoreboard whenever the DUT returns read data.
    always @(negedge clk) begin
        if (!rst) begin
            if (sb_q.size() > 0 && sb_q[0].due < cyc) begin
                chk("rd_return_timeout", 32'(cyc), 32'(sb_q[0].due));
                void'(sb_q.pop_front());
            end
            if (rdout_valid) begin
                if (sb_q.size() == 0) begin
                    chk("rdout_valid_unexpected", 32'(rdout_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("rd_return_cycle", 32'(cyc), 32'(e.due));
                    chk("rd_return_data", 32'(rdout_data), 32'(e.d));
                    last_data = e.d;
                end
            end else begin
                chk("rdout_data_hold", 32'(rdout_data), 32'(last_data));
            end
        end
    end

    // One clock of stimulus; checks grants, RAM drive and conflict count,
    // then advances the model. Returns the DUT's sampled readies.
    task automatic step(input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic rv, input logic [AW-1:0] ra,
                        output logic mw, output logic mr, output logic dw, output logic dr);
        logic ew, er;
        @(posedge clk); #1;
        wr_valid = wv; wr_addr = wa; wr_data = wd;
        rd_valid = rv; rd_addr = ra;
        @(negedge clk);
        ew = !rst && wv && (!rv || m_burst < MAXB);
        er = !rst && rv && !ew;
        dw = wr_ready; dr = rd_ready;
        chk("wr_ready", 32'(wr_ready), 32'(ew));
        chk("rd_ready", 32'(rd_ready), 32'(er));
        chk("ram_wr_en", 32'(ram_wr_en), 32'(e_we));
        chk("ram_addr", 32'(ram_addr), 32'(e_addr));
        if (e_we) chk("ram_wr_data", 32'(ram_wr_data), 32'(e_wdata));
        chk("conflict_cnt", 32'(conflict_cnt), 32'(m_conf));
        if (ew) begin
            ref_mem[wa] = wd;
            e_addr = wa; e_wdata = wd; e_we = 1'b1;
        end else if (er) begin
            e_addr = ra; e_we = 1'b0;
            sb_q.push_back('{d: ref_mem[ra], due: cyc + LAT});
        end else begin
            e_we = 1'b0;
        end
        if (!rv || er) m_burst = 0;
        else if (ew)   m_burst++;
        if (wv && rv && m_conf != 32'hFFFF) m_conf++;
        mw = ew; mr = er;
    endtask

    task automatic idle(input int n);
        logic a, b, c, d;
        for (int i = 0; i < n; i++) step(0, '0, '0, 0, '0, a, b, c, d);
    endtask

    task automatic do_reset();
        logic a, b, c, d;
        step(0, '0, '0, 0, '0, a, b, c, d);   // let a final write commit
        @(posedge clk); #1;
        rst = 1'b1; wr_valid = 0; rd_valid = 0;
        #1;
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_wr_data", 32'(ram_wr_data), 32'd0);
        chk("rst_ram_wr_en", 32'(ram_wr_en), 32'd0);
        chk("rst_rdout_valid", 32'(rdout_valid), 32'd0);
        chk("rst_rdout_data", 32'(rdout_data), 32'd0);
        chk("rst_conflict_cnt", 32'(conflict_cnt), 32'd0);
        wr_valid = 1; rd_valid = 1;
        #1;
        chk("rst_wr_ready", 32'(wr_ready), 32'd0);
        chk("rst_rd_ready", 32'(rd_ready), 32'd0);
        wr_valid = 0; rd_valid = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        sb_q.delete();
        m_burst = 0; m_conf = 0;
        e_addr = '0; e_wdata = '0; e_we = 1'b0; last_data = '0;
        for (int i = 0; i < 4; i++) begin
            step(0, '0, '0, 0, '0, a, b, c, d);
            chk("post_rst_no_rdout", 32'(rdout_valid), 32'd0);
        end
    endtask

    initial begin
        logic mw, mr, dw, dr;
        logic wv_p, rv_p;
        logic [AW-1:0] wa_p, ra_p;
        logic [DW-1:0] wd_p;
        string pat, exp_pat;

        do_reset();

        // Write then read the same address on consecutive grants.
        step(1, 11'h005, 16'hA5A5, 0, '0, mw, mr, dw, dr);
        step(0, '0, '0, 1, 11'h005, mw, mr, dw, dr);
        chk("wtr_ram_wr_en", 32'(ram_wr_en), 32'd1);
        chk("wtr_ram_addr", 32'(ram_addr), 32'h005);
        idle(5);

        // Starvation guard: both requesters held for 12 cycles.
        do_reset();
        pat = ""; exp_pat = "WWWWRWWWWRWW";
        for (int i = 0; i < 12; i++) begin
            step(1, 11'(100 + i), 16'(i), 1, 11'h005, mw, mr, dw, dr);
            pat = {pat, dw ? "W" : (dr ? "R" : "-")};
        end
        for (int i = 0; i < 12; i++)
            chk($sformatf("starve_gnt_%0d", i), 32'(pat[i]), 32'(exp_pat[i]));
        idle(1);
        chk("starve_conflict_12", 32'(conflict_cnt), 32'd12);
        idle(4);

        // Read stream: preload addr*3, then 8 back-to-back reads.
        for (int i = 0; i < 8; i++) step(1, 11'(i), 16'(i * 3), 0, '0, mw, mr, dw, dr);
        for (int i = 0; i < 8; i++) step(0, '0, '0, 1, 11'(i), mw, mr, dw, dr);
        idle(4);
        chk("stream_drained", 32'(sb_q.size()), 32'd0);

        // Idle and hold.
        idle(5);
        chk("idle_ram_wr_en", 32'(ram_wr_en), 32'd0);
        chk("idle_rdout_data", 32'(rdout_data), 32'd21);

        // Randomised traffic with a mid-stream reset.
        wv_p = 0; rv_p = 0; wa_p = '0; ra_p = '0; wd_p = '0;
        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                do_reset();
                wv_p = 0; rv_p = 0;
            end
            if (!wv_p) begin
                wv_p = 1'($urandom_range(0, 1));
                wa_p = 11'($urandom_range(0, 15));
                wd_p = 16'($urandom);
            end
            if (!rv_p) begin
                rv_p = 1'($urandom_range(0, 1));
                ra_p = 11'($urandom_range(0, 15));
            end
            step(wv_p, wa_p, wd_p, rv_p, ra_p, mw, mr, dw, dr);
            if (mw) wv_p = 0;
            if (mr) rv_p = 0;
        end
        idle(5);

        // Saturation of the conflict counter.
        do_reset();
        for (int i = 0; i < 70000; i++)
            step(1, 11'($urandom_range(0, 31)), 16'($urandom), 1, 11'($urandom_range(0, 31)), mw, mr, dw, dr);
        idle(1);
        chk("sat_conflict", 32'(conflict_cnt), 32'hFFFF);
        idle(5);
        chk("final_drained", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
